// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage: two-entry skid buffer with a registered in_ready,
// synchronous flush to bubble, and an occupancy count.
module pipe_skid_stage #(
  parameter int                DATA_W = 64,
  parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q, in_ready_d;
  logic              it, ot;

  assign it        = in_valid & in_ready_q;
  assign ot        = out_valid & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_data_q;
  assign occupancy = state_q;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    unique case (state_q)
      EMPTY: begin
        if (it) begin
          state_d     = ONE;
          main_data_d = in_data;
        end
      end
      ONE: begin
        if (it && ot) begin
          main_data_d = in_data;
        end else if (it) begin
          state_d     = TWO;
          skid_data_d = in_data;
        end else if (ot) begin
          state_d     = EMPTY;
          main_data_d = BUBBLE;
        end
      end
      TWO: begin
        // in_ready is low here, so only the drain side can move
        if (ot) begin
          state_d     = ONE;
          main_data_d = skid_data_q;
          skid_data_d = BUBBLE;
        end
      end
      default: begin
        state_d     = EMPTY;
        main_data_d = BUBBLE;
        skid_data_d = BUBBLE;
      end
    endcase
    if (flush) begin
      state_d     = EMPTY;
      main_data_d = BUBBLE;
      skid_data_d = BUBBLE;
    end
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_data_q <= BUBBLE;
      skid_data_q <= BUBBLE;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
    end
  end

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised, elastic pipeline stage register: the successor to the fixed 2×32-bit IF/ID stall register. It carries an arbitrary-width payload between two pipeline stages using valid/ready handshakes on both sides. A 2-entry skid buffer sustains one transfer per cycle with a fully registered `in_ready`. It adds synchronous flush with bubble insertion and an occupancy output. It is instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB.

## Interface
- `DATA_W`, 64, payload width in bits; must be ≥ 1. Default carries {next_PC, instruction}.
- `BUBBLE`, {DATA_W{1'b0}}, value driven on `out_data` whenever `out_valid` = 0.
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `flush`  input  1  synchronous; discards all held entries.
- `in_valid`  input  1  upstream offers `in_data`.
- `in_ready`  output  1  stage can accept; registered, with no combinational path from any input.
- `in_data`  input  DATA_W  upstream payload.
- `out_valid`  output  1  `out_data` holds a valid entry.
- `out_ready`  input  1  downstream accepts this cycle.
- `out_data`  output  DATA_W  head entry, or `BUBBLE` when empty.
- `occupancy`  output  2  number of held entries, 0..2.

## Operation
- Storage: main register (drives `out_data`/`out_valid`) and skid register, each with a valid bit.
- Transfer definitions:
  - Input transfer (IT) = `in_valid` & `in_ready`.
  - Output transfer (OT) = `out_valid` & `out_ready`.
- States, encoded by `occupancy`: EMPTY (0), ONE (1), TWO (2). `in_ready` = (next state ≠ TWO), registered.
- EMPTY:
  - IT → ONE; main ← `in_data`.
  - Otherwise stay EMPTY.
- ONE:
  - IT & OT → ONE; main ← `in_data`.
  - IT & !OT → TWO; skid ← `in_data`.
  - !IT & OT → EMPTY; main data ← `BUBBLE`.
  - Neither → hold.
- TWO (`in_ready` = 0, so no IT is possible):
  - OT → ONE; main ← skid; skid data ← `BUBBLE`.
  - Otherwise hold.
- Ordering is strict FIFO; an entry is never duplicated or dropped except by flush.
- Stall equivalent: holding `out_ready` = 0 freezes the head entry indefinitely; `out_data` stays stable while `out_valid` = 1 and `out_ready` = 0.
- Upstream rule: once `in_valid` = 1, `in_data` is held until IT. The stage does not check this.
- Flush:
  - Next state EMPTY; both valid bits cleared; both data registers ← `BUBBLE`; `in_ready` ← 1.
  - An IT in the flush cycle counts as accepted and is discarded.
  - An OT in the flush cycle counts as completed; downstream owns that entry.
- Priority: `reset` > `flush` > handshake logic.

## Timing
- Reset values (cycle after `reset` sampled high): `out_valid` = 0, `out_data` = `BUBBLE`, `in_ready` = 1, `occupancy` = 0, skid data = `BUBBLE`.
- Reset mid-operation behaves identically to flush, but also overrides `flush`.
- Latency: IT at edge N → `out_valid` = 1 with that data after edge N (usable in cycle N+1).
- Throughput: 1 entry/cycle while `out_ready` = 1, with no bubbles.
- Backpressure:
  - `out_ready` dropping in ONE with IT present → TWO; `in_ready` = 0 from the next cycle.
  - Exactly one extra entry is absorbed.
- Leaving TWO: after an OT in TWO, `in_ready` = 1 from the next cycle. Refill takes one cycle, so worst-case throughput under toggling `out_ready` is 1/2.
- Flush:
  - Effective at the edge where it is sampled.
  - Next cycle: `out_valid` = 0, `out_data` = `BUBBLE`, `in_ready` = 1.
  - A new IT is allowed in that same next cycle.
- `occupancy` updates on the same edge as the state change.

## Test plan
- Reset then idle: assert `reset` 2 cycles with `in_valid` = 1 → `out_valid` = 0, `out_data` = 0, `in_ready` = 1, `occupancy` = 0; nothing captured.
- Streaming: `out_ready` = 1; feed 0x1…0x8 back-to-back → `out_data` = 0x1…0x8 on consecutive cycles, each 1 cycle after its IT; `occupancy` ≤ 1; `in_ready` never 0.
- Skid/backpressure: feed 0xA, 0xB, 0xC on consecutive cycles with `out_ready` = 0 from cycle 1.
  - 0xA held on `out_data`; 0xB absorbed; `occupancy` = 2; `in_ready` = 0; 0xC held upstream.
  - Release `out_ready` → outputs 0xA, 0xB, 0xC in order.
- Flush in TWO: fill with 0x11, 0x22, then `flush` = 1 with `in_valid` = 1, `in_data` = 0x33.
  - Next cycle: `out_valid` = 0, `out_data` = `BUBBLE`, `occupancy` = 0, `in_ready` = 1.
  - 0x33 never appears on `out_data`.
- Reset vs flush: assert `reset` and `flush` together in ONE → same result as reset. Then inject 0x44 → appears one cycle later.
- Random: DATA_W = 8, random `in_valid`/`out_ready`/rare `flush` for 10k cycles against a reference queue model.
  - Output order matches the model; no loss or duplication outside flush.
  - `out_data` is stable under stall; `in_ready` = 0 iff `occupancy` = 2.
